rpn_sequencer: RTL and testbench

- Upstream command stage for the 3-bit-opcode stack: push 110, pop 111, add 100, multiply 101, no-op 000.
- Accepts a valid/ready stream of RPN tokens (operands and operators) and issues exactly one stack opcode per token.
- Tracks stack depth, rejects illegal operations before they reach the stack, and returns the final result and sticky signed-overflow status per expression.

---
 rtl/rpn_sequencer_if.sv | 13 +
 rtl/rpn_sequencer.sv | 146 ++++++++++++++
 tb/tb_rpn_sequencer.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rpn_sequencer_if.sv
// Token stream between the RPN producer and the sequencer.
// Transfer happens on tok_valid & tok_ready at a clk edge.
interface rpn_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             tok_valid;
  logic             tok_ready;
  logic [1:0]       tok_kind;
  logic [WIDTH-1:0] tok_value;

  modport master (output tok_valid, tok_kind, tok_value, input tok_ready);
  modport slave  (input tok_valid, tok_kind, tok_value, output tok_ready);
endinterface

// File: rtl/rpn_sequencer.sv
// RPN token sequencer: turns a token stream into one stack opcode per token,
// guards stack depth, flushes the stack on error and reports results.
module rpn_sequencer #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  rpn_sequencer_if.slave   tok,
  output logic [2:0]       stk_opcode,
  output logic [WIDTH-1:0] stk_data,
  input  logic [WIDTH-1:0] stk_output,
  input  logic             stk_overflow,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             ovf_flag,
  output logic             err_valid,
  output logic [1:0]       err_code,
  output logic             busy
);
  localparam int DW = $clog2(DEPTH + 1);

  localparam logic [1:0] K_OPND = 2'b00;
  localparam logic [1:0] K_ADD  = 2'b01;
  localparam logic [1:0] K_MUL  = 2'b10;
  localparam logic [1:0] K_END  = 2'b11;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_PUSH = 3'b110;
  localparam logic [2:0] OP_POP  = 3'b111;

  typedef enum logic [2:0] {
    S_ACCEPT, S_EXEC, S_CHECK, S_ERR, S_FLUSH, S_DRAIN
  } state_t;

  state_t          state, nxt;
  logic [DW-1:0]   depth;
  logic [1:0]      kind_q;
  logic            err_end;
  logic            rdy_en;
  logic            ready;
  logic            xfer;
  logic [1:0]      chk_code;

  assign tok.tok_ready = ready;
  assign xfer          = tok.tok_valid & ready;
  assign busy          = (state != S_ACCEPT);

  // Legality of the offered token against the current depth
  always_comb begin
    chk_code = 2'b00;
    case (tok.tok_kind)
      K_OPND:       if (depth == DW'(DEPTH)) chk_code = 2'b01;
      K_ADD, K_MUL: if (depth < DW'(2))      chk_code = 2'b10;
      default:      if (depth != DW'(1))     chk_code = 2'b11;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_ACCEPT;
    else     state <= nxt;
  end

  always_comb begin
    nxt        = state;
    ready      = 1'b0;
    stk_opcode = OP_NOP;
    err_valid  = 1'b0;
    case (state)
      S_ACCEPT: begin
        ready = rdy_en;
        if (xfer) nxt = (chk_code != 2'b00) ? S_ERR : S_EXEC;
      end
      S_EXEC: begin
        case (kind_q)
          K_OPND:  stk_opcode = OP_PUSH;
          K_ADD:   stk_opcode = OP_ADD;
          K_MUL:   stk_opcode = OP_MUL;
          default: stk_opcode = OP_POP;
        endcase
        nxt = S_CHECK;
      end
      S_CHECK: nxt = S_ACCEPT;
      S_ERR: begin
        err_valid = 1'b1;
        if (depth != '0) nxt = S_FLUSH;
        else             nxt = err_end ? S_ACCEPT : S_DRAIN;
      end
      S_FLUSH: begin
        stk_opcode = OP_POP;
        if (depth <= DW'(1)) nxt = err_end ? S_ACCEPT : S_DRAIN;
      end
      S_DRAIN: begin
        ready = rdy_en;
        if (xfer && tok.tok_kind == K_END) nxt = S_ACCEPT;
      end
      default: nxt = S_ACCEPT;
    endcase
  end

  // rdy_en keeps tok_ready low for the first cycle after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      depth        <= '0;
      kind_q       <= K_OPND;
      err_end      <= 1'b0;
      rdy_en       <= 1'b0;
      stk_data     <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      ovf_flag     <= 1'b0;
      err_code     <= 2'b00;
    end else begin
      rdy_en       <= 1'b1;
      result_valid <= 1'b0;
      if (result_valid) ovf_flag <= 1'b0;
      case (state)
        S_ACCEPT: if (xfer) begin
          kind_q <= tok.tok_kind;
          if (chk_code != 2'b00) begin
            err_code <= chk_code;
            err_end  <= (tok.tok_kind == K_END);
          end else if (tok.tok_kind == K_OPND) begin
            stk_data <= tok.tok_value;
          end
        end
        S_EXEC: begin
          if (kind_q == K_OPND) depth <= depth + DW'(1);
          else                  depth <= depth - DW'(1);
        end
        S_CHECK: begin
          if (kind_q == K_ADD || kind_q == K_MUL) ovf_flag <= ovf_flag | stk_overflow;
          if (kind_q == K_END) begin
            result       <= stk_output;
            result_valid <= 1'b1;
          end
        end
        S_ERR:   ovf_flag <= 1'b0;
        S_FLUSH: if (depth != '0) depth <= depth - DW'(1);
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_rpn_sequencer.sv
// Scoreboard bench for rpn_sequencer with a behavioural stack attached.
module tb_rpn_sequencer;
  localparam int DEPTH = 16;
  localparam int WIDTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rpn_sequencer_if #(.WIDTH(WIDTH)) tok ();

  logic [2:0]       stk_opcode;
  logic [WIDTH-1:0] stk_data, stk_output, result;
  logic             stk_overflow, result_valid, ovf_flag, err_valid, busy;
  logic [1:0]       err_code;

  rpn_sequencer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .tok(tok),
    .stk_opcode(stk_opcode), .stk_data(stk_data),
    .stk_output(stk_output), .stk_overflow(stk_overflow),
    .result(result), .result_valid(result_valid), .ovf_flag(ovf_flag),
    .err_valid(err_valid), .err_code(err_code), .busy(busy)
  );

  // Behavioural stack, reset by the same rst
  logic [WIDTH-1:0] mem [DEPTH];
  int               cnt;
  logic [WIDTH-1:0] opa, opb, top1, sum;
  logic [31:0]      prod;
  logic             add_ovf, mul_ovf;

  always_comb begin
    opa  = '0;
    opb  = '0;
    top1 = '0;
    if (cnt >= 2) begin opa = mem[cnt-2]; opb = mem[cnt-1]; end
    if (cnt >= 1) top1 = mem[cnt-1];
  end
  assign sum     = opa + opb;
  assign add_ovf = (opa[15] == opb[15]) && (sum[15] != opa[15]);
  assign prod    = $signed({{16{opa[15]}}, opa}) * $signed({{16{opb[15]}}, opb});
  assign mul_ovf = (prod[31:15] != {17{prod[15]}});

  always @(posedge clk) begin
    if (rst) begin
      cnt          <= 0;
      stk_output   <= '0;
      stk_overflow <= 1'b0;
    end else begin
      case (stk_opcode)
        3'b110: if (cnt < DEPTH) begin
          mem[cnt]   <= stk_data;
          cnt        <= cnt + 1;
          stk_output <= stk_data;
        end
        3'b111: if (cnt > 0) begin
          cnt        <= cnt - 1;
          stk_output <= top1;
        end
        3'b100: if (cnt >= 2) begin
          mem[cnt-2]   <= sum;
          cnt          <= cnt - 1;
          stk_output   <= sum;
          stk_overflow <= add_ovf;
        end
        3'b101: if (cnt >= 2) begin
          mem[cnt-2]   <= prod[15:0];
          cnt          <= cnt - 1;
          stk_output   <= prod[15:0];
          stk_overflow <= mul_ovf;
        end
        default: ;
      endcase
    end
  end

  typedef struct { logic [2:0] op; logic [WIDTH-1:0] data; } op_t;
  typedef struct { logic [WIDTH-1:0] val; logic ovf; } res_t;
  op_t        op_q[$];
  res_t       res_q[$];
  logic [1:0] err_q[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops an expectation whenever the DUT presents something
  always @(negedge clk) begin
    if (!rst) begin
      if (stk_opcode != 3'b000) begin
        if (op_q.size() == 0) chk("unexpected_opcode", {29'd0, stk_opcode}, 32'd0);
        else begin
          op_t e;
          e = op_q.pop_front();
          chk("opcode", {29'd0, stk_opcode}, {29'd0, e.op});
          if (e.op == 3'b110) chk("push_data", {16'd0, stk_data}, {16'd0, e.data});
        end
      end
      if (result_valid) begin
        if (res_q.size() == 0) chk("unexpected_result", 32'd1, 32'd0);
        else begin
          res_t r;
          r = res_q.pop_front();
          chk("result", {16'd0, result}, {16'd0, r.val});
          chk("ovf_flag", {31'd0, ovf_flag}, {31'd0, r.ovf});
        end
      end
      if (err_valid) begin
        if (err_q.size() == 0) chk("unexpected_err", {30'd0, err_code}, 32'd0);
        else chk("err_code", {30'd0, err_code}, {30'd0, err_q.pop_front()});
      end
    end
  end

  task automatic exp_op(input logic [2:0] op, input logic [WIDTH-1:0] d);
    op_t e;
    e.op = op; e.data = d;
    op_q.push_back(e);
  endtask

  task automatic exp_res(input logic [WIDTH-1:0] v, input logic o);
    res_t r;
    r.val = v; r.ovf = o;
    res_q.push_back(r);
  endtask

  // Present a token and hold it until the DUT is ready to take it
  task automatic offer(input logic [1:0] k, input logic [WIDTH-1:0] v);
    int n;
    n = 0;
    @(negedge clk);
    tok.tok_valid = 1'b1;
    tok.tok_kind  = k;
    tok.tok_value = v;
    while (!tok.tok_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!tok.tok_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: tok_ready stayed 0, wanted 1");
    end
  endtask

  task automatic send(input logic [1:0] k, input logic [WIDTH-1:0] v);
    offer(k, v);
    @(posedge clk);
    #1 tok.tok_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_tok_ready"}, {31'd0, tok.tok_ready}, 32'd0);
    chk({tag, "_opcode"}, {29'd0, stk_opcode}, 32'd0);
    chk({tag, "_stk_data"}, {16'd0, stk_data}, 32'd0);
    chk({tag, "_result"}, {16'd0, result}, 32'd0);
    chk({tag, "_result_valid"}, {31'd0, result_valid}, 32'd0);
    chk({tag, "_ovf"}, {31'd0, ovf_flag}, 32'd0);
    chk({tag, "_err_valid"}, {31'd0, err_valid}, 32'd0);
    chk({tag, "_err_code"}, {30'd0, err_code}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tok.tok_valid = 1'b0;
    tok.tok_kind  = 2'b00;
    tok.tok_value = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk_reset_outputs("reset");
    @(negedge clk) rst = 1'b0;

    // 3,4,ADD,END -> 7
    exp_op(3'b110, 16'd3); exp_op(3'b110, 16'd4); exp_op(3'b100, 0); exp_op(3'b111, 0);
    exp_res(16'd7, 1'b0);
    send(2'b00, 16'd3); send(2'b00, 16'd4); send(2'b01, 0); send(2'b11, 0);
    idle(4);
    chk("depth_after_expr1", cnt, 0);

    // Signed overflow is sticky for one expression only
    exp_op(3'b110, 16'h7fff); exp_op(3'b110, 16'h0001); exp_op(3'b100, 0); exp_op(3'b111, 0);
    exp_res(16'h8000, 1'b1);
    send(2'b00, 16'h7fff); send(2'b00, 16'h0001); send(2'b01, 0); send(2'b11, 0);
    exp_op(3'b110, 16'd2); exp_op(3'b110, 16'd3); exp_op(3'b101, 0); exp_op(3'b111, 0);
    exp_res(16'd6, 1'b0);
    send(2'b00, 16'd2); send(2'b00, 16'd3); send(2'b10, 0); send(2'b11, 0);
    idle(4);

    // Operator on empty stack: error, drain to END, no stack ops
    err_q.push_back(2'b10);
    send(2'b01, 0); send(2'b00, 16'd5); send(2'b11, 0);
    exp_op(3'b110, 16'd9); exp_op(3'b111, 0); exp_res(16'd9, 1'b0);
    send(2'b00, 16'd9); send(2'b11, 0);
    idle(4);

    // Fill to DEPTH, one more push errors and flushes everything
    for (int i = 0; i < DEPTH; i++) begin
      exp_op(3'b110, WIDTH'(i + 100));
      send(2'b00, WIDTH'(i + 100));
    end
    err_q.push_back(2'b01);
    for (int i = 0; i < DEPTH; i++) exp_op(3'b111, 0);
    send(2'b00, 16'd77);
    send(2'b00, 16'd1); send(2'b01, 0); send(2'b11, 0);
    idle(4);
    chk("stack_empty_after_flush", cnt, 0);
    chk("busy_idle", {31'd0, busy}, 32'd0);

    // END with depth 2: error 11, two pops, no result
    exp_op(3'b110, 16'd1); exp_op(3'b110, 16'd2);
    err_q.push_back(2'b11);
    exp_op(3'b111, 0); exp_op(3'b111, 0);
    send(2'b00, 16'd1); send(2'b00, 16'd2); send(2'b11, 0);
    idle(6);
    chk("stack_empty_after_end_err", cnt, 0);
    chk("err_code_held", {30'd0, err_code}, 32'd3);

    // Reset during EXEC of a push while tok_valid stays high
    exp_op(3'b110, 16'd42);
    offer(2'b00, 16'd42);
    @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 chk_reset_outputs("midrst");
    exp_op(3'b110, 16'd42);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1 chk("ready_after_rst", {31'd0, tok.tok_ready}, 32'd1);
    @(posedge clk);
    #1 tok.tok_valid = 1'b0;
    exp_op(3'b111, 0); exp_res(16'd42, 1'b0);
    send(2'b11, 0);
    idle(6);

    chk("op_q_empty", op_q.size(), 0);
    chk("res_q_empty", res_q.size(), 0);
    chk("err_q_empty", err_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
